// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store front-end for a 16-bit word memory with a
// combinational read port. Accepts one request at a time, range-checks the
// address, inserts WAIT_STATES idle cycles, performs one memory cycle and
// returns a held response with an error flag.
module mem_access_ctrl #(
    parameter int unsigned MEM_SIZE    = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        addr_bad;

    // Unsigned full-width compare; zero-extend so MEM_SIZE itself is out of range.
    assign addr_bad = {16'd0, req_addr} >= MEM_SIZE;

    // Request sequencing: latch, wait, single memory cycle, held response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        wait_cnt <= WAIT_LOAD;
                        if (addr_bad) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end else if (WAIT_STATES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : mem_rdata;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // State decodes; rst gating keeps req_ready low for the whole reset pulse.
    assign req_ready   = (state == IDLE) && !rst;
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_wr      = (state == ACCESS) && we_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Four instances with WAIT_STATES
// 1, 0, 15 and 3, each with its own behavioural memory.
module tb_mem_access_ctrl;

    localparam int NI = 4;

    logic        clk;
    logic        rst         [NI];
    logic        req_valid   [NI];
    logic        req_ready   [NI];
    logic        req_we      [NI];
    logic [15:0] req_addr    [NI];
    logic [15:0] req_wdata   [NI];
    logic        resp_valid  [NI];
    logic        resp_ready  [NI];
    logic [15:0] resp_rdata  [NI];
    logic        resp_err    [NI];
    logic [15:0] mem_address [NI];
    logic [15:0] mem_wdata   [NI];
    logic        mem_wr      [NI];
    logic [15:0] mem_rdata   [NI];

    logic [15:0] mem     [NI][32];
    logic [15:0] ref_mem [NI][32];

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    function automatic int ws_of(input int k);
        case (k)
            0: return 1;
            1: return 0;
            2: return 15;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 15 : 3;
        mem_access_ctrl #(.MEM_SIZE(32), .WAIT_STATES(WS)) u_dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]),
            .mem_address(mem_address[g]), .mem_wdata(mem_wdata[g]),
            .mem_wr(mem_wr[g]), .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = (mem_address[g] < 16'd32) ? mem[g][mem_address[g][4:0]] : 16'h0000;
        always @(posedge clk) begin
            if (mem_wr[g] && mem_address[g] < 16'd32)
                mem[g][mem_address[g][4:0]] <= mem_wdata[g];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request/response transaction on instance k with scoreboard checking.
    task automatic txn(input int k, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input int stall, input bit noise);
        int   ws;
        bit   err;
        int   n;
        int   lat;
        int   wr_n;
        int   wr_c;
        exp_t e;
        logic [15:0] rd0;
        ws  = ws_of(k);
        err = (a >= 16'd32);
        e.rd  = (we || err) ? 16'h0000 : ref_mem[k][a[4:0]];
        e.err = err;
        e.lat = err ? 1 : ws + 2;

        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b required 1", k, req_ready[k]);
            req_valid[k] = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!noise) req_valid[k] = 1'b0;
        else begin
            req_addr[k]  = a + 16'd1;
            req_wdata[k] = ~wd;
        end

        lat  = 0;
        wr_n = 0;
        wr_c = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (noise) begin
                tests++;
                if (req_ready[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_ready inst=%0d cycle=%0d req_ready=%b required 0", k, c, req_ready[k]);
                end
                req_addr[k]  = req_addr[k] + 16'd3;
                req_wdata[k] = req_wdata[k] ^ 16'h1357;
            end
            if (mem_wr[k] === 1'b1) begin
                wr_n++;
                wr_c = c;
            end
            if (!err && c <= ws + 1) begin
                tests++;
                if (mem_address[k] !== a || mem_wdata[k] !== wd) begin
                    fails++;
                    $display("FAIL mem_stable inst=%0d cycle=%0d addr=%h wdata=%h required %h %h",
                             k, c, mem_address[k], mem_wdata[k], a, wd);
                end
            end
            if (resp_valid[k] === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (noise) req_valid[k] = 1'b0;

        e = sb.pop_front();
        tests++;
        if (lat !== e.lat) begin
            fails++;
            $display("FAIL latency inst=%0d got=%0d required %0d", k, lat, e.lat);
        end
        tests++;
        if (resp_rdata[k] !== e.rd || resp_err[k] !== e.err) begin
            fails++;
            $display("FAIL response inst=%0d rdata=%h err=%b required %h %b",
                     k, resp_rdata[k], resp_err[k], e.rd, e.err);
        end
        tests++;
        if ((we && !err) ? (wr_n != 1 || wr_c != ws + 1) : (wr_n != 0)) begin
            fails++;
            $display("FAIL mem_wr_count inst=%0d count=%0d cycle=%0d required %0d at %0d",
                     k, wr_n, wr_c, (we && !err) ? 1 : 0, ws + 1);
        end

        rd0 = resp_rdata[k];
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            tests++;
            if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== rd0 || resp_err[k] !== e.err || req_ready[k] !== 1'b0) begin
                fails++;
                $display("FAIL resp_hold inst=%0d stall=%0d valid=%b rdata=%h ready=%b required 1 %h 0",
                         k, s, resp_valid[k], resp_rdata[k], req_ready[k], rd0);
            end
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[k] = 1'b0;
        @(negedge clk);
        tests++;
        if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
            fails++;
            $display("FAIL back_to_idle inst=%0d resp_valid=%b req_ready=%b required 0 1",
                     k, resp_valid[k], req_ready[k]);
        end
        if (we && !err) begin
            ref_mem[k][a[4:0]] = wd;
            tests++;
            if (mem[k][a[4:0]] !== wd) begin
                fails++;
                $display("FAIL mem_content inst=%0d addr=%h got=%h required %h", k, a, mem[k][a[4:0]], wd);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 16'h0 ||
                resp_err[k] !== 1'b0 || mem_wr[k] !== 1'b0 || mem_address[k] !== 16'h0 || mem_wdata[k] !== 16'h0) begin
                fails++;
                $display("FAIL reset_outputs inst=%0d ready=%b valid=%b rdata=%h err=%b wr=%b addr=%h wdata=%h required all 0",
                         k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k], mem_wr[k], mem_address[k], mem_wdata[k]);
            end
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_release inst=%0d ready=%b valid=%b required 1 0", k, req_ready[k], resp_valid[k]);
            end
        end
    endtask

    task automatic test_store();
        txn(0, 1'b1, 16'd5, 16'hBEEF, 0, 1'b0);
    endtask

    task automatic test_load_backpressure();
        txn(0, 1'b0, 16'd5, 16'h0000, 4, 1'b0);
    endtask

    task automatic test_out_of_range();
        txn(0, 1'b1, 16'd0, 16'h5A5A, 0, 1'b0);
        txn(0, 1'b1, 16'd32, 16'h1111, 0, 1'b0);
        txn(0, 1'b1, 16'hFFFF, 16'h2222, 1, 1'b0);
        tests++;
        if (mem[0][0] !== 16'h5A5A) begin
            fails++;
            $display("FAIL oor_mem_word0 got=%h required 5a5a", mem[0][0]);
        end
    endtask

    task automatic test_wait_builds();
        txn(1, 1'b1, 16'd31, 16'hC0DE, 0, 1'b0);
        txn(1, 1'b0, 16'd31, 16'h0000, 0, 1'b0);
        txn(2, 1'b1, 16'd31, 16'hF00D, 0, 1'b0);
        txn(2, 1'b0, 16'd31, 16'h0000, 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        txn(3, 1'b1, 16'd7, 16'h1111, 0, 1'b0);
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_we[3]    = 1'b1;
        req_addr[3]  = 16'd7;
        req_wdata[3] = 16'h1234;
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        @(posedge clk);
        #3;
        rst[3] = 1'b1;
        #1;
        tests++;
        if (req_ready[3] !== 1'b0 || resp_valid[3] !== 1'b0 || resp_rdata[3] !== 16'h0 || resp_err[3] !== 1'b0 ||
            mem_wr[3] !== 1'b0 || mem_address[3] !== 16'h0 || mem_wdata[3] !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs ready=%b valid=%b wr=%b addr=%h wdata=%h required all 0",
                     req_ready[3], resp_valid[3], mem_wr[3], mem_address[3], mem_wdata[3]);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst[3] = 1'b0;
            tests++;
            if (mem_wr[3] !== 1'b0 || resp_valid[3] !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_quiet cycle=%0d wr=%b valid=%b required 0 0", c, mem_wr[3], resp_valid[3]);
            end
        end
        tests++;
        if (mem[3][7] !== 16'h1111) begin
            fails++;
            $display("FAIL mid_reset_mem got=%h required 1111", mem[3][7]);
        end
        txn(3, 1'b0, 16'd7, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_protocol();
        txn(0, 1'b1, 16'd11, 16'h7777, 0, 1'b0);
        txn(0, 1'b1, 16'd10, 16'hAAAA, 0, 1'b1);
        tests++;
        if (mem[0][11] !== 16'h7777) begin
            fails++;
            $display("FAIL protocol_neighbour got=%h required 7777", mem[0][11]);
        end
        txn(0, 1'b0, 16'd10, 16'h0000, 0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_addr[k]   = 16'h0;
            req_wdata[k]  = 16'h0;
            resp_ready[k] = 1'b0;
        end
        test_reset();
        test_store();
        test_load_backpressure();
        test_out_of_range();
        test_wait_builds();
        test_reset_mid();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front-end placed directly upstream of the 16-bit data memory (combinational read, write on posedge clk).
- Accepts one word request at a time from the execute stage over a valid/ready handshake.
- Range-checks the address against MEM_SIZE and inserts WAIT_STATES programmable wait cycles.
- Drives the memory's address/wdata/wr inputs, captures read data, and returns a held response with an error flag.

Parameters:
- MEM_SIZE, 32, number of 16-bit words in the downstream memory; valid addresses are 0..MEM_SIZE-1.
- WAIT_STATES, 1, idle cycles inserted between request acceptance and the memory access cycle; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  16  word address.
- req_wdata  input  16  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  16  load data; 0 for stores and errors.
- resp_err  output  1  address out of range.
- mem_address  output  16  to memory address.
- mem_wdata  output  16  to memory wdata.
- mem_wr  output  1  to memory wr.
- mem_rdata  input  16  from memory rdata.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst high):
  - state=IDLE; wait counter=0; latched we/addr/wdata=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_wr=0, mem_address=0, mem_wdata=0.
  - req_ready=0 while rst is high.
- States: IDLE, WAIT, ACCESS, RESP (2-bit encoding).
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at a clock edge, latch req_we, req_addr and req_wdata, and load the counter with WAIT_STATES.
  - Next state:
    - req_addr >= MEM_SIZE: RESP with resp_err=1, resp_rdata=0. No memory cycle is issued.
    - Otherwise, if WAIT_STATES == 0: ACCESS.
    - Otherwise: WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 1 the next state is ACCESS.
  - Spends exactly WAIT_STATES cycles in WAIT.
- ACCESS (exactly one cycle):
  - mem_wr = latched_we (combinational decode of state, high only in this cycle).
  - On the closing edge, register resp_rdata = we ? 0 : mem_rdata; set resp_err=0.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - When resp_ready=1 at an edge: clear resp_valid and go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Memory-side outputs:
  - mem_address and mem_wdata are driven from the latched registers in every state.
  - They are stable throughout WAIT and ACCESS and hold their last value in IDLE and RESP.
  - mem_wr=0 in every state except ACCESS.
- Latency (acceptance edge = cycle 0):
  - ACCESS occurs in cycle WAIT_STATES+1.
  - resp_valid is first high in cycle WAIT_STATES+2.
  - Out-of-range requests: resp_valid high in cycle 1.
- Address check: unsigned full 16-bit compare. 0xFFFF and MEM_SIZE itself both produce errors.
- Reset during WAIT: the pending store is dropped and mem_wr never asserts.
- Reset during ACCESS: mem_wr falls immediately (asynchronously); memory contents are undefined only if rst rises less than the setup time before the edge.
- Reset during RESP: the response is discarded and resp_valid drops immediately.
- req_valid while not ready: ignored. The requester must hold the request until ready.
- Request inputs changing after acceptance: no effect (latched copy is used).
- Throughput: one request per WAIT_STATES+3 cycles, plus response back-pressure.

Test Plan:
- Reset then store, WAIT_STATES=1, no stall:
  - Stimulus: assert rst; release; store addr=5, wdata=0xBEEF; resp_ready=1.
  - Required: mem_wr high exactly one cycle (cycle 2) with mem_address=5 and mem_wdata=0xBEEF; resp_valid in cycle 3 with err=0, rdata=0.
- Load with back-pressure:
  - Stimulus: memory model holds 0xBEEF at addr 5; load addr=5; resp_ready=0 for 4 cycles.
  - Required: resp_rdata=0xBEEF held with resp_valid=1 for 4 cycles; req_ready=0 throughout; IDLE one cycle after handshake.
- Out-of-range store:
  - Stimulus: store addr=32 (MEM_SIZE=32) and separately addr=0xFFFF.
  - Required: resp_err=1 in cycle 1; mem_wr never asserts; memory word 0 unchanged.
- WAIT_STATES=0 and WAIT_STATES=15 builds:
  - Stimulus: load addr=31.
  - Required: resp_valid first high in cycle 2 and cycle 17 respectively; addr 31 accepted with err=0.
- Reset mid-operation:
  - Stimulus: WAIT_STATES=3; store addr=7, wdata=0x1234; rst pulsed during the second WAIT cycle.
  - Required: mem_wr never high; all outputs 0 during rst; addr 7 retains its prior value; next request is processed normally.
- Protocol robustness:
  - Stimulus: req_valid held high continuously with changing addr/wdata during WAIT.
  - Required: only the value present at the acceptance edge is used; exactly one access per handshake; no acceptance while req_ready=0.
